// File: rtl/sgm_pkg.sv
// Shared types and constants for the SGM front end (census stage and friends).
// Census bit positions are fixed here so the matching-cost stage decodes them identically.
package sgm_pkg;

  localparam int PIXEL_W  = 8;
  localparam int CENSUS_W = 8;
  localparam int Y_W      = 11;

  // Neighbour -> descriptor bit; T/M/B = two rows up / one row up / current row.
  localparam int CB_TL = 7;
  localparam int CB_TC = 6;
  localparam int CB_TR = 5;
  localparam int CB_ML = 4;
  localparam int CB_MR = 3;
  localparam int CB_BL = 2;
  localparam int CB_BC = 1;
  localparam int CB_BR = 0;

  typedef logic [PIXEL_W-1:0]  pixel_t;
  typedef logic [CENSUS_W-1:0] census_t;

  function automatic census_t census_desc(
    input pixel_t c,
    input pixel_t tl, input pixel_t tc, input pixel_t tr,
    input pixel_t ml, input pixel_t mr,
    input pixel_t bl, input pixel_t bc, input pixel_t br
  );
    census_t d;
    d        = '0;
    d[CB_TL] = (tl < c);
    d[CB_TC] = (tc < c);
    d[CB_TR] = (tr < c);
    d[CB_ML] = (ml < c);
    d[CB_MR] = (mr < c);
    d[CB_BL] = (bl < c);
    d[CB_BC] = (bc < c);
    d[CB_BR] = (br < c);
    return d;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-clock line RAM with independent write and read addresses and a one-cycle
// synchronous read; a same-address read and write in one cycle returns the old word.
module line_buffer
  import sgm_pkg::*;
#(
  parameter int DEPTH = 1280,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               re,
  input  logic [AW-1:0]      rd_addr,
  output logic [PIXEL_W-1:0] rd_data
);

  logic [PIXEL_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/census_3x3.sv
// Streaming 3x3 census transform with two line buffers and a fixed 2-cycle latency.
// Optional CENSUS_DBG_CENTER_EN adds dbg_center (window centre luminance, masked like pixel_out).
module census_3x3
  import sgm_pkg::*;
#(
  parameter int MAX_WIDTH = 1280,
  parameter int X_W       = $clog2(MAX_WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               de_in,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic [PIXEL_W-1:0] pixel_in,
  output logic               de_out,
  output logic               h_sync_out,
  output logic               v_sync_out,
  output logic [CENSUS_W-1:0] pixel_out
`ifdef CENSUS_DBG_CENTER_EN
  ,
  output logic [PIXEL_W-1:0] dbg_center
`endif
);

  localparam int LB_AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [X_W-1:0] X_MAX = X_W'(MAX_WIDTH);

  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             de_prev;
  logic             lb_we;
  logic [LB_AW-1:0] lb_addr;

  logic             de_d1, hs_d1, vs_d1, lb_we_d1;
  pixel_t           pix_d1;
  logic [X_W-1:0]   x_d1;
  logic [Y_W-1:0]   y_d1;
  logic [LB_AW-1:0] lb_addr_d1;
  pixel_t           lb1_q, lb2_q;

  // Two history columns per row; the third (newest) column is the live tap
  // (lb2_q / lb1_q / pix_d1), so the compare can be registered in cycle 2.
  pixel_t           top1, top2, mid1, mid2, bot1, bot2;

  census_t          census;
  logic             out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      de_prev <= 1'b0;
    end else begin
      de_prev <= de_in;
      if (!de_in)          x <= '0;
      else if (x != X_MAX) x <= x + 1'b1;
      if (v_sync_in)                            y <= '0;
      else if (de_prev && !de_in && (y != '1))  y <= y + 1'b1;
    end
  end

  assign lb_we   = de_in && (x < X_MAX);
  assign lb_addr = x[LB_AW-1:0];

  line_buffer #(.DEPTH(MAX_WIDTH), .AW(LB_AW)) u_lb1 (
    .clk     (clk),
    .we      (lb_we),
    .wr_addr (lb_addr),
    .wr_data (pixel_in),
    .re      (lb_we),
    .rd_addr (lb_addr),
    .rd_data (lb1_q)
  );

  // LB1's read word lands a cycle later, so it is written into LB2 at the delayed address.
  line_buffer #(.DEPTH(MAX_WIDTH), .AW(LB_AW)) u_lb2 (
    .clk     (clk),
    .we      (lb_we_d1),
    .wr_addr (lb_addr_d1),
    .wr_data (lb1_q),
    .re      (lb_we),
    .rd_addr (lb_addr),
    .rd_data (lb2_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      de_d1      <= 1'b0;
      hs_d1      <= 1'b0;
      vs_d1      <= 1'b0;
      lb_we_d1   <= 1'b0;
      pix_d1     <= '0;
      x_d1       <= '0;
      y_d1       <= '0;
      lb_addr_d1 <= '0;
      top1       <= '0;
      top2       <= '0;
      mid1       <= '0;
      mid2       <= '0;
      bot1       <= '0;
      bot2       <= '0;
    end else begin
      de_d1      <= de_in;
      hs_d1      <= h_sync_in;
      vs_d1      <= v_sync_in;
      lb_we_d1   <= lb_we;
      pix_d1     <= pixel_in;
      x_d1       <= x;
      y_d1       <= y;
      lb_addr_d1 <= lb_addr;
      if (de_d1) begin
        top2 <= top1;
        top1 <= lb2_q;
        mid2 <= mid1;
        mid1 <= lb1_q;
        bot2 <= bot1;
        bot1 <= pix_d1;
      end
    end
  end

  always_comb begin
    census    = census_desc(mid1,
                            top2, top1, lb2_q,
                            mid2, lb1_q,
                            bot2, bot1, pix_d1);
    out_valid = de_d1 && (x_d1 >= X_W'(2)) && (x_d1 < X_MAX) && (y_d1 >= Y_W'(2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      pixel_out  <= '0;
    end else begin
      de_out     <= de_d1;
      h_sync_out <= hs_d1;
      v_sync_out <= vs_d1;
      pixel_out  <= out_valid ? census : '0;
    end
  end

`ifdef CENSUS_DBG_CENTER_EN
  always_ff @(posedge clk) begin
    if (rst) dbg_center <= '0;
    else     dbg_center <= out_valid ? mid1 : '0;
  end
`endif

endmodule

// File: tb/tb_census_3x3.sv
// Bench for census_3x3 (MAX_WIDTH=8): line-level reference model on every cycle,
// plus a table of fixed expectations for the flat, dark-pixel, gradient, overlong and reset frames.
module tb_census_3x3;

  localparam int MW = 8;

  logic       clk = 1'b0;
  logic       rst, de_in, h_sync_in, v_sync_in;
  logic [7:0] pixel_in;
  logic       de_out, h_sync_out, v_sync_out;
  logic [7:0] pixel_out;
`ifdef CENSUS_DBG_CENTER_EN
  logic [7:0] dbg_center;
`endif

  census_3x3 #(.MAX_WIDTH(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .de_in      (de_in),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .pixel_in   (pixel_in),
    .de_out     (de_out),
    .h_sync_out (h_sync_out),
    .v_sync_out (v_sync_out),
    .pixel_out  (pixel_out)
`ifdef CENSUS_DBG_CENTER_EN
    ,
    .dbg_center (dbg_center)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] pix;
    int         r;
    int         c;
  } exp_t;

  typedef struct {
    int         pat;
    int         r;
    int         c;
    logic [7:0] want;
  } spot_t;

  exp_t       eq[$];
  spot_t      spots[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] img [8][16];
  logic [7:0] obs [8][16];

  // Reference state: row/column position per the counter rules, and whole-line images
  // of the two previously completed lines plus the line in progress.
  int         mrow, mcol, line_len;
  logic       mde_prev;
  logic [7:0] l1 [16];
  logic [7:0] l2 [16];
  logic [7:0] cur [16];

  function automatic exp_t idle_exp();
    exp_t e;
    e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0; e.pix = 8'h00; e.r = -1; e.c = -1;
    return e;
  endfunction

  function automatic logic [7:0] census_ref(int c);
    logic [7:0] ctr, d;
    logic [7:0] nb [8];
    ctr = l1[c-1];
    nb  = '{l2[c-2], l2[c-1], l2[c], l1[c-2], l1[c], cur[c-2], cur[c-1], cur[c]};
    d   = 8'h00;
    for (int i = 0; i < 8; i++) if (nb[i] < ctr) d[7-i] = 1'b1;
    return d;
  endfunction

  function automatic exp_t model_step(logic de, logic hs, logic vs, logic [7:0] pix, int r, int c);
    exp_t e;
    e.de = de; e.hs = hs; e.vs = vs; e.pix = 8'h00; e.r = r; e.c = c;
    if (de && mcol < MW) cur[mcol] = pix;
    if (de && mcol >= 2 && mcol < MW && mrow >= 2) e.pix = census_ref(mcol);
    if (mde_prev && !de) begin
      for (int i = 0; i < line_len && i < MW; i++) begin
        l2[i] = l1[i];
        l1[i] = cur[i];
      end
      line_len = 0;
    end
    if (de) line_len++;
    if (vs) mrow = 0;
    else if (mde_prev && !de && mrow < 2047) mrow++;
    mcol     = de ? ((mcol < MW) ? mcol + 1 : MW) : 0;
    mde_prev = de;
    return e;
  endfunction

  task automatic slot(input logic r_in, input logic de, input logic hs, input logic vs,
                      input logic [7:0] pix, input int r, input int c);
    exp_t g, e;
    @(posedge clk);
    #1;
    g = eq.pop_front();
    vectors++;
    if (de_out !== g.de || h_sync_out !== g.hs || v_sync_out !== g.vs || pixel_out !== g.pix) begin
      miscompares++;
      $display("FAIL stream vec %0d (x=%0d y=%0d): got de=%b hs=%b vs=%b pix=%h, want de=%b hs=%b vs=%b pix=%h",
               vectors, g.c, g.r, de_out, h_sync_out, v_sync_out, pixel_out, g.de, g.hs, g.vs, g.pix);
    end
    if (g.r >= 0) obs[g.r][g.c] = pixel_out;
    rst = r_in; de_in = de; h_sync_in = hs; v_sync_in = vs; pixel_in = pix;
    if (r_in) begin
      eq[eq.size()-1] = idle_exp();
      e = idle_exp();
      mrow = 0; mcol = 0; mde_prev = 1'b0; line_len = 0;
    end else begin
      e = model_step(de, hs, vs, pix, r, c);
    end
    eq.push_back(e);
  endtask

  task automatic send_frame(input int w, input int h, input int blank, input int rst_row, input bit vs_de);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 16; c++) obs[r][c] = 8'hEE;
    slot(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom), -1, -1);
    if (vs_de) slot(1'b0, 1'b1, 1'b0, 1'b1, 8'($urandom), -1, -1);
    slot(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom), -1, -1);
    slot(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), -1, -1);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) slot(1'b0, 1'b1, 1'b0, 1'b0, img[r][c], r, c);
      for (int b = 0; b < blank; b++)
        slot((r + 1 == rst_row) && (b == blank - 1), 1'b0, b == 1, 1'b0, 8'($urandom), -1, -1);
    end
  endtask

  task automatic check_spots(input int pat);
    foreach (spots[i]) begin
      if (spots[i].pat == pat) begin
        vectors++;
        if (obs[spots[i].r][spots[i].c] !== spots[i].want) begin
          miscompares++;
          $display("FAIL spot pattern %0d (x=%0d y=%0d): got %h want %h",
                   pat, spots[i].c, spots[i].r, obs[spots[i].r][spots[i].c], spots[i].want);
        end
      end
    end
  endtask

  function automatic void add_spot(int pat, int r, int c, logic [7:0] want);
    spot_t s;
    s.pat = pat; s.r = r; s.c = c; s.want = want;
    spots.push_back(s);
  endfunction

  initial begin
    // 0 flat, 1 dark pixel, 2 gradient, 3 overlong gradient, 4 reset before row 3
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 8; c++) begin
        add_spot(0, r, c, 8'h00);
        add_spot(2, r, c, (r >= 2 && c >= 2) ? 8'h94 : 8'h00);
        add_spot(4, r, c, (r >= 2 && r != 3 && r != 4 && c >= 2) ? 8'h94 : 8'h00);
      end
      for (int c = 0; c < 10; c++)
        add_spot(3, r, c, (r >= 2 && c >= 2 && c < 8) ? 8'h94 : 8'h00);
    end
    add_spot(1, 3, 3, 8'h08);
    add_spot(1, 3, 4, 8'h00);
    add_spot(1, 4, 5, 8'h80);

    rst = 1'b1; de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; pixel_in = 8'h00;
    mrow = 0; mcol = 0; line_len = 0; mde_prev = 1'b0;
    for (int i = 0; i < 16; i++) begin l1[i] = 8'h00; l2[i] = 8'h00; cur[i] = 8'h00; end
    eq.push_back(idle_exp());
    eq.push_back(idle_exp());
    repeat (3) @(posedge clk);

    // reset held with toggling controls, then release and watch de track
    slot(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, -1, -1);
    slot(1'b1, 1'b0, 1'b1, 1'b0, 8'h66, -1, -1);
    slot(1'b1, 1'b1, 1'b0, 1'b1, 8'h77, -1, -1);
    slot(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, -1, -1);
    slot(1'b0, 1'b0, 1'b1, 1'b0, 8'h22, -1, -1);
    slot(1'b0, 1'b1, 1'b0, 1'b0, 8'h33, -1, -1);
    slot(1'b0, 1'b1, 1'b0, 1'b0, 8'h44, -1, -1);
    slot(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, -1, -1);
    slot(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, -1, -1);

    for (int r = 0; r < 8; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'd100;
    send_frame(8, 6, 4, -1, 1'b0);
    check_spots(0);

    for (int r = 0; r < 8; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'd50;
    img[2][3] = 8'd10;
    send_frame(8, 6, 4, -1, 1'b0);
    check_spots(1);

    for (int r = 0; r < 8; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'(10 * c);
    send_frame(8, 6, 4, -1, 1'b0);
    check_spots(2);
    send_frame(10, 6, 4, -1, 1'b0);
    check_spots(3);
    send_frame(8, 6, 4, 3, 1'b0);
    check_spots(4);

    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 16; c++)
          img[r][c] = (k % 2 == 0) ? 8'(100 + $urandom_range(0, 3)) : 8'($urandom);
      send_frame($urandom_range(3, 8), $urandom_range(3, 6), $urandom_range(2, 5), -1, k % 3 == 1);
    end

    repeat (3) slot(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, -1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
